// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - per-bit debounce filter with registered rise/fall pulses
// Each bit commits a new level only after STABLE_CYCLES consecutive enabled mismatching samples.
module sync_debounce #(
   parameter int               WIDTH         = 4,
   parameter int               STABLE_CYCLES = 8,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sync_i,
   input  logic             sample_en_i,
   output logic [WIDTH-1:0] stable_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             changed_o
);

   localparam int               CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   always_comb begin
      stable_d = stable_q;
      rise_d   = '0;
      fall_d   = '0;
      for (int b = 0; b < WIDTH; b++) begin
         cnt_d[b] = cnt_q[b];
         // A sample matching the accepted level restarts the qualification window.
         if (sync_i[b] == stable_q[b]) begin
            cnt_d[b] = '0;
         end else if (sample_en_i) begin
            if (cnt_q[b] == CNT_LAST) begin
               stable_d[b] = sync_i[b];
               cnt_d[b]    = '0;
               rise_d[b]   = sync_i[b];
               fall_d[b]   = ~sync_i[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
         end
      end
      changed_d = |(rise_d | fall_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q  <= RESET_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         for (int b = 0; b < WIDTH; b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         stable_q  <= stable_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
         for (int b = 0; b < WIDTH; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

   assign stable_o  = stable_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign changed_o = changed_q;

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - directed self-checking bench for sync_debounce
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sync_debounce;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sync_i;
   logic       sample_en_i;
   logic [3:0] stable_o;
   logic [3:0] rise_o;
   logic [3:0] fall_o;
   logic       changed_o;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] pulse_seen;

   sync_debounce #(
      .WIDTH(4),
      .STABLE_CYCLES(8),
      .RESET_VAL(4'b0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sync_i(sync_i),
      .sample_en_i(sample_en_i),
      .stable_o(stable_o),
      .rise_o(rise_o),
      .fall_o(fall_o),
      .changed_o(changed_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         pulse_seen = pulse_seen | rise_o | fall_o;
      end
   endtask

   initial begin
      rst         = 1'b1;
      sync_i      = 4'b0000;
      sample_en_i = 1'b1;
      pulse_seen  = 4'b0000;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("reset_stable", stable_o, 4'b0000);
      check("reset_rise", rise_o, 4'b0000);
      check("reset_fall", fall_o, 4'b0000);
      check("reset_changed", changed_o, 1'b0);

      // clean rise on bit 0
      sync_i = 4'b0001;
      tick(7);
      check("rise_pre_commit", stable_o, 4'b0000);
      tick(1);
      check("rise_stable", stable_o, 4'b0001);
      check("rise_pulse", rise_o, 4'b0001);
      check("rise_changed", changed_o, 1'b1);
      check("rise_nofall", fall_o, 4'b0000);
      tick(1);
      check("rise_pulse_end", rise_o, 4'b0000);
      check("rise_changed_end", changed_o, 1'b0);
      check("rise_hold", stable_o, 4'b0001);

      // asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_stable", stable_o, 4'b0000);
      check("async_rst_rise", rise_o, 4'b0000);
      check("async_rst_changed", changed_o, 1'b0);
      sync_i = 4'b0000;
      tick(1);
      rst = 1'b0;
      tick(1);

      // glitch rejection: 7 high, 1 low, 7 high, then the 8th commits
      pulse_seen = 4'b0000;
      sync_i = 4'b0001;
      tick(7);
      sync_i = 4'b0000;
      tick(1);
      sync_i = 4'b0001;
      tick(7);
      check("glitch_stable", stable_o, 4'b0000);
      check("glitch_no_pulse", pulse_seen, 4'b0000);
      tick(1);
      check("glitch_commit", stable_o, 4'b0001);
      check("glitch_commit_rise", rise_o, 4'b0001);
      tick(1);

      // gated sampling: enable on every 3rd edge, commit at edge 24
      sync_i = 4'b0011;
      for (int k = 1; k <= 24; k++) begin
         sample_en_i = (k % 3 == 0);
         tick(1);
         if (k == 23) check("gated_pre_commit", stable_o, 4'b0001);
      end
      check("gated_stable", stable_o, 4'b0011);
      check("gated_rise", rise_o, 4'b0010);
      check("gated_changed", changed_o, 1'b1);
      sample_en_i = 1'b1;
      tick(1);
      check("gated_pulse_end", rise_o, 4'b0000);

      // 0011 -> 0100: two falls and one rise together
      sync_i = 4'b0100;
      tick(8);
      check("multi_stable", stable_o, 4'b0100);
      check("multi_rise", rise_o, 4'b0100);
      check("multi_fall", fall_o, 4'b0011);
      tick(1);

      // 0100 -> 0010 simultaneous rise and fall
      sync_i = 4'b0010;
      tick(7);
      check("simul_pre_commit", stable_o, 4'b0100);
      tick(1);
      check("simul_stable", stable_o, 4'b0010);
      check("simul_rise", rise_o, 4'b0010);
      check("simul_fall", fall_o, 4'b0100);
      check("simul_changed", changed_o, 1'b1);
      tick(1);
      check("simul_fall_end", fall_o, 4'b0000);

      // reset mid-count on bit 3 (bit 1 also mismatches once stable returns to 0)
      sync_i = 4'b1010;
      tick(5);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_stable", stable_o, 4'b0000);
      check("midrst_fall", fall_o, 4'b0000);
      pulse_seen = 4'b0000;
      tick(1);
      rst = 1'b0;
      tick(7);
      check("midrst_pre_commit", stable_o, 4'b0000);
      check("midrst_no_pulse", pulse_seen, 4'b0000);
      tick(1);
      check("midrst_commit", stable_o, 4'b1010);
      check("midrst_rise", rise_o, 4'b1010);
      tick(1);
      check("midrst_pulse_end", changed_o, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
